// File: rtl/data_memory_if.sv
// Load/store bus between the data cache and the backing data memory.
// Field names match the core's memory stage signals.
interface data_memory_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [2:0]            AddrMode;
    logic [ADDR_WIDTH-1:0] A;
    logic [DATA_WIDTH-1:0] WD;
    logic                  WE;
    logic [DATA_WIDTH-1:0] RD;

    modport master (
        output AddrMode,
        output A,
        output WD,
        output WE,
        input  RD
    );

    modport slave (
        input  AddrMode,
        input  A,
        input  WD,
        input  WE,
        output RD
    );
endinterface

// File: rtl/data_memory.sv
// Byte-addressed little-endian RV32 data memory: combinational load port with
// width select and sign/zero extension, clocked byte/half/word store port.
module data_memory #(
    parameter int unsigned ADDR_WIDTH    = 32,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned MEM_ADDR_BITS = 17
) (
    input  logic          clk,
    input  logic          rst,
    data_memory_if.slave  bus
);

    localparam int unsigned MEM_BYTES = 32'd1 << MEM_ADDR_BITS;
    localparam int unsigned LANES     = 4;

    localparam logic [2:0] MODE_B  = 3'b000;
    localparam logic [2:0] MODE_H  = 3'b001;
    localparam logic [2:0] MODE_BU = 3'b100;
    localparam logic [2:0] MODE_HU = 3'b101;

    logic [7:0]               mem [MEM_BYTES];
    logic [MEM_ADDR_BITS-1:0] idx [LANES];
    logic [LANES-1:0]         byte_en;
    logic [7:0]               b0, b1, b2, b3;
    logic [31:0]              rd_word;
    logic                     unused_addr_hi;

    // Upper address bits alias; they are intentionally not decoded.
    assign unused_addr_hi = ^bus.A[ADDR_WIDTH-1:MEM_ADDR_BITS];

    // Consecutive byte indices, wrapping modulo the memory size.
    always_comb begin
        for (int unsigned k = 0; k < LANES; k++) begin
            idx[k] = bus.A[MEM_ADDR_BITS-1:0] + MEM_ADDR_BITS'(k);
        end
    end

    // Store width to byte lanes; unlisted encodings behave as word.
    always_comb begin
        byte_en = 4'b1111;
        case (bus.AddrMode)
            MODE_B, MODE_BU: byte_en = 4'b0001;
            MODE_H, MODE_HU: byte_en = 4'b0011;
            default:         byte_en = 4'b1111;
        endcase
    end

    // Reset clears the whole array and also cancels any store in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < MEM_BYTES; i++) begin
                mem[MEM_ADDR_BITS'(i)] <= 8'h00;
            end
        end else if (bus.WE) begin
            for (int unsigned k = 0; k < LANES; k++) begin
                if (byte_en[k]) begin
                    mem[idx[k]] <= bus.WD[8*k +: 8];
                end
            end
        end
    end

    // Load path: no bypass, so a store becomes visible only after its edge.
    always_comb begin
        b0      = mem[idx[0]];
        b1      = mem[idx[1]];
        b2      = mem[idx[2]];
        b3      = mem[idx[3]];
        rd_word = {b3, b2, b1, b0};
        case (bus.AddrMode)
            MODE_B:  rd_word = {{24{b0[7]}}, b0};
            MODE_BU: rd_word = {24'h000000, b0};
            MODE_H:  rd_word = {{16{b1[7]}}, b1, b0};
            MODE_HU: rd_word = {16'h0000, b1, b0};
            default: rd_word = {b3, b2, b1, b0};
        endcase
    end

    assign bus.RD = DATA_WIDTH'(rd_word);

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: directed literal checks plus random
// traffic compared every cycle against a sparse byte-array reference model.
module tb_data_memory;

    localparam int unsigned MASK = 32'h0001_FFFF;

    logic clk;
    logic rst;
    data_memory_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    data_memory #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .MEM_ADDR_BITS(17)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int tests;
    int fails;
    bit compare_on;

    logic [7:0] model [int unsigned];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] mget(int unsigned i);
        if (model.exists(i & MASK)) return model[i & MASK];
        return 8'h00;
    endfunction

    function automatic logic [31:0] model_rd(logic [31:0] a, logic [2:0] mode);
        logic [7:0] b [4];
        for (int k = 0; k < 4; k++) b[k] = mget(a + 32'(k));
        case (mode)
            3'b000:  return {{24{b[0][7]}}, b[0]};
            3'b100:  return {24'h0, b[0]};
            3'b001:  return {{16{b[1][7]}}, b[1], b[0]};
            3'b101:  return {16'h0, b[1], b[0]};
            default: return {b[3], b[2], b[1], b[0]};
        endcase
    endfunction

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: RD=%08h expected %08h (A=%08h mode=%03b t=%0t)",
                     name, act, exp, bus.A, bus.AddrMode, $time);
        end
    endfunction

    // Reference store: applied on the same edge the DUT samples.
    always @(posedge clk) begin
        if (!rst && bus.WE === 1'b1) begin
            int n;
            n = (bus.AddrMode == 3'b000 || bus.AddrMode == 3'b100) ? 1 :
                (bus.AddrMode == 3'b001 || bus.AddrMode == 3'b101) ? 2 : 4;
            for (int k = 0; k < n; k++) model[(bus.A + 32'(k)) & MASK] = bus.WD[8*k +: 8];
        end
    end

    always @(posedge rst) model.delete();

    always @(negedge clk) begin
        if (compare_on) check("cycle", bus.RD, model_rd(bus.A, bus.AddrMode));
    end

    task automatic drive(input logic we, input logic [31:0] a,
                         input logic [31:0] wd, input logic [2:0] mode);
        @(posedge clk);
        #1;
        bus.WE = we;
        bus.A = a;
        bus.WD = wd;
        bus.AddrMode = mode;
    endtask

    task automatic read_expect(string name, input logic [31:0] a,
                               input logic [2:0] mode, input logic [31:0] exp);
        drive(1'b0, a, 32'h0, mode);
        @(negedge clk);
        check(name, bus.RD, exp);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        compare_on = 1'b0;
        rst = 1'b1;
        bus.WE = 1'b0;
        bus.A = 32'h0001_0000;
        bus.WD = 32'h0;
        bus.AddrMode = 3'b010;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        compare_on = 1'b1;

        read_expect("rst_w",  32'h0001_0000, 3'b010, 32'h0);
        read_expect("rst_b",  32'h0001_0000, 3'b000, 32'h0);
        read_expect("rst_h",  32'h0001_0000, 3'b001, 32'h0);
        read_expect("rst_bu", 32'h0001_0000, 3'b100, 32'h0);
        read_expect("rst_hu", 32'h0001_0000, 3'b101, 32'h0);

        drive(1'b1, 32'h100, 32'hDEAD_BEEF, 3'b010);
        read_expect("sw_w",  32'h100, 3'b010, 32'hDEAD_BEEF);
        read_expect("sw_b",  32'h100, 3'b000, 32'hFFFF_FFEF);
        read_expect("sw_bu", 32'h103, 3'b100, 32'h0000_00DE);
        read_expect("sw_h",  32'h102, 3'b001, 32'hFFFF_DEAD);
        read_expect("sw_hu", 32'h100, 3'b101, 32'h0000_BEEF);

        drive(1'b1, 32'h101, 32'h1234_5678, 3'b000);
        read_expect("sb_merge", 32'h100, 3'b010, 32'hDEAD_78EF);
        drive(1'b1, 32'h102, 32'h0000_ABCD, 3'b001);
        read_expect("sh_merge", 32'h100, 3'b010, 32'hABCD_78EF);

        drive(1'b1, 32'h1FFFE, 32'h1122_3344, 3'b010);
        read_expect("wrap0", 32'h1FFFE, 3'b100, 32'h44);
        read_expect("wrap1", 32'h1FFFF, 3'b100, 32'h33);
        read_expect("wrap2", 32'h00000, 3'b100, 32'h22);
        read_expect("wrap3", 32'h00001, 3'b100, 32'h11);
        read_expect("alias", 32'h0003_FFFE, 3'b010, 32'h1122_3344);

        repeat (3) drive(1'b0, 32'h100, 32'hFFFF_FFFF, 3'b010);
        read_expect("we0_hold", 32'h100, 3'b010, 32'hABCD_78EF);

        drive(1'b1, 32'h100, 32'h5566_7788, 3'b010);
        @(negedge clk);
        check("rdw_old", bus.RD, 32'hABCD_78EF);
        @(posedge clk);
        #1;
        check("rdw_new", bus.RD, 32'h5566_7788);
        bus.WE = 1'b0;

        drive(1'b1, 32'h200, 32'hCAFE_BABE, 3'b010);
        read_expect("cafe", 32'h200, 3'b010, 32'hCAFE_BABE);
        drive(1'b1, 32'h200, 32'h1212_1212, 3'b010);
        #2 rst = 1'b1;
        #1 check("rst_async", bus.RD, 32'h0);
        @(posedge clk);
        #1 check("rst_hold", bus.RD, 32'h0);
        rst = 1'b0;
        bus.WE = 1'b0;
        read_expect("rst_nowrite", 32'h200, 3'b010, 32'h0);
        read_expect("rst_cleared", 32'h100, 3'b010, 32'h0);

        for (int c = 0; c < 3000; c++) begin
            logic [31:0] a;
            a = $urandom;
            case ($urandom % 3)
                0:       a[16:0] = 17'h100 + 17'($urandom % 16);
                1:       a[16:0] = 17'h1FFFC + 17'($urandom % 8);
                default: a[16:0] = 17'($urandom);
            endcase
            drive(1'($urandom % 2), a, $urandom, 3'($urandom % 8));
            if ($urandom % 400 == 0) begin
                #2 rst = 1'b1;
                #3 rst = 1'b0;
            end
        end

        @(posedge clk);
        #1 compare_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/data_memory.md
Name: data_memory

Overview:
- Byte-addressed, little-endian data memory for the RV32 core's load/store path.
- Asynchronous (combinational) read port with RISC-V load-width selection and sign/zero extension.
- Synchronous write port with byte/halfword/word store widths.
- Sits behind the data cache, which forwards address, store data, write enable and access mode unchanged.

Parameters:
- ADDR_WIDTH, 32, width of the byte address input A.
- DATA_WIDTH, 32, width of WD and RD; fixed at 32 for this design.
- MEM_ADDR_BITS, 17, number of low address bits decoded; storage is 2^MEM_ADDR_BITS bytes (128 KiB).

Ports:
- clk  input  1  system clock; all writes on rising edge.
- rst  input  1  asynchronous, active-high reset; clears every memory byte to 0x00.
- AddrMode  input  3  access mode in RISC-V funct3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- A  input  ADDR_WIDTH  byte address.
- WD  input  DATA_WIDTH  store data; low byte/halfword used for narrow stores.
- WE  input  1  write enable, sampled on rising clk.
- RD  output  DATA_WIDTH  load data, combinational.

Behaviour:
- Addressing
  - Effective byte index = A[MEM_ADDR_BITS-1:0]; upper address bits ignored, so addresses alias modulo 2^MEM_ADDR_BITS.
  - Multi-byte accesses use bytes idx, idx+1, idx+2, idx+3, each computed modulo 2^MEM_ADDR_BITS; wraps at the top of memory.
  - No alignment requirement; misaligned H/W accesses are legal and use the same byte sequence.
- Read (combinational, zero latency; RD follows A, AddrMode and memory contents in the same cycle)
  - B: sign-extend byte[idx] to 32 bits.
  - BU: zero-extend byte[idx].
  - H: sign-extend {byte[idx+1], byte[idx]}.
  - HU: zero-extend the same halfword.
  - W and any unlisted encoding (011, 110, 111): {byte[idx+3], byte[idx+2], byte[idx+1], byte[idx]}.
  - RD is computed regardless of WE.
- Write (rising clk, when WE=1 and rst=0)
  - B/BU: byte[idx] <= WD[7:0].
  - H/HU: byte[idx] <= WD[7:0], byte[idx+1] <= WD[15:8].
  - W and unlisted encodings: all four bytes, WD[7:0] lowest address first.
  - Bytes outside the access width are unchanged.
  - WE=0: no state change.
- Read-during-write: RD shows pre-write contents until the clock edge, then reflects the new data combinationally. No write-first bypass.
- Reset
  - rst=1 immediately (asynchronously) zeroes all bytes, so RD=0x00000000 for every address and mode while rst is high and after release until written.
  - Writes are ignored while rst=1.
  - Reset asserted mid-cycle while WE=1 cancels that write.
- No internal state other than the byte array; no handshake, always ready.

Test Plan:
- Reset then read: pulse rst, A=0x00010000, AddrMode=010 -> RD=0x00000000; repeat with all five modes -> all 0.
- Word store/load: WE=1, A=0x100, AddrMode=010, WD=0xDEADBEEF, one clk -> W read 0xDEADBEEF; B at 0x100 -> 0xFFFFFFEF; BU at 0x103 -> 0x000000DE; H at 0x102 -> 0xFFFFDEAD; HU at 0x100 -> 0x0000BEEF.
- Byte/half merge: after the above, store B WD=0x12345678 at 0x101 -> W at 0x100 reads 0xDEAD78EF; store H WD=0x0000ABCD at 0x102 -> W reads 0xABCD78EF.
- Misaligned and wrap: W store 0x11223344 at 0x1FFFE -> BU at 0x1FFFE=0x44, 0x1FFFF=0x33, 0x00000=0x22, 0x00001=0x11. Aliasing: W read at 0x0003FFFE -> 0x11223344.
- WE=0 and read-during-write: WE=0 with WD=0xFFFFFFFF over several edges -> contents unchanged. With WE=1, RD holds old value before the edge and new value after it.
- Async reset mid-operation: write 0xCAFEBABE to 0x200, then assert rst between edges with WE=1 -> RD drops to 0 immediately, no write occurs, and 0x200 reads 0 after release.
